// File: rtl/gp_pattern_detect.sv
// Serial pattern checker: hunts for a programmed periodic pattern, locks to its phase,
// then flags per-bit mismatches with a saturating error count.
module gp_pattern_detect #(
    parameter logic [15:0] PATTERN_DATA   = 16'h0,
    parameter logic [4:0]  PATTERN_LEN    = 5'd16,
    parameter int unsigned LOCK_PERIODS   = 2,
    parameter int unsigned UNLOCK_PERIODS = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN,
    input  logic       CLR,
    output logic       LOCKED,
    output logic       FRAME,
    output logic       ERR,
    output logic [7:0] ERR_COUNT,
    output logic [3:0] PHASE
);

    if (PATTERN_LEN < 5'd2 || PATTERN_LEN > 5'd16 ||
        LOCK_PERIODS < 1 || LOCK_PERIODS > 15 ||
        UNLOCK_PERIODS < 1 || UNLOCK_PERIODS > 15) begin : g_param_check
        $fatal(1, "gp_pattern_detect: illegal parameter value");
    end

    localparam logic [4:0]  LEN_M1   = PATTERN_LEN - 5'd1;
    localparam logic [3:0]  LAST     = LEN_M1[3:0];
    localparam logic [16:0] ONE      = 17'h1;
    localparam logic [15:0] MASK     = 16'((ONE << PATTERN_LEN) - ONE);
    localparam logic [3:0]  LOCK_N   = 4'(LOCK_PERIODS);
    localparam logic [3:0]  UNLOCK_N = 4'(UNLOCK_PERIODS);

    typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_t;

    state_t      state_q, state_d;
    // Only 15 history bits are stored; together with IN they form the 16-bit window.
    logic [14:0] win_q, win_d;
    logic [4:0]  fill_q, fill_d;
    logic [3:0]  phase_q, phase_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  bad_q, bad_d;
    logic        pbad_q, pbad_d;
    logic        locked_q, locked_d;
    logic        frame_q, frame_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [15:0] nxt;
    logic        hit;
    logic        mism;
    logic        period_bad;
    logic [3:0]  phase_dec;
    logic [3:0]  good_inc;
    logic [3:0]  bad_nxt;

    always_comb begin
        nxt        = {win_q, IN};
        hit        = (fill_q >= LEN_M1) && ((nxt & MASK) == (PATTERN_DATA & MASK));
        mism       = (IN != PATTERN_DATA[phase_q]);
        phase_dec  = (phase_q == 4'd0) ? LAST : phase_q - 4'd1;
        good_inc   = good_q + 4'd1;
        period_bad = pbad_q | mism;
        bad_nxt    = period_bad ? bad_q + 4'd1 : 4'd0;

        state_d  = state_q;
        win_d    = nxt[14:0];
        fill_d   = (fill_q == PATTERN_LEN) ? fill_q : fill_q + 5'd1;
        phase_d  = phase_q;
        good_d   = good_q;
        bad_d    = bad_q;
        pbad_d   = pbad_q;
        locked_d = locked_q;
        frame_d  = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            S_HUNT: begin
                phase_d  = 4'd0;
                locked_d = 1'b0;
                if (hit) begin
                    phase_d = LAST;
                    good_d  = 4'd1;
                    bad_d   = 4'd0;
                    pbad_d  = 1'b0;
                    if (LOCK_PERIODS == 1) begin
                        state_d  = S_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        state_d = S_VERIFY;
                    end
                end
            end
            S_VERIFY: begin
                if (mism) begin
                    state_d = S_HUNT;
                    good_d  = 4'd0;
                    phase_d = 4'd0;
                end else begin
                    phase_d = phase_dec;
                    if (phase_q == 4'd0) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_d  = S_LOCKED;
                            locked_d = 1'b1;
                            bad_d    = 4'd0;
                            pbad_d   = 1'b0;
                        end
                    end
                end
            end
            S_LOCKED: begin
                phase_d = phase_dec;
                pbad_d  = period_bad;
                if (mism) begin
                    err_d = 1'b1;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end
                if (phase_q == 4'd0) begin
                    frame_d = 1'b1;
                    pbad_d  = 1'b0;
                    bad_d   = bad_nxt;
                    if (bad_nxt == UNLOCK_N) begin
                        state_d  = S_HUNT;
                        locked_d = 1'b0;
                        phase_d  = 4'd0;
                        good_d   = 4'd0;
                        bad_d    = 4'd0;
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase

        if (CLR) cnt_d = 8'd0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_HUNT;
            win_q    <= '0;
            fill_q   <= '0;
            phase_q  <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            pbad_q   <= 1'b0;
            locked_q <= 1'b0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            fill_q   <= fill_d;
            phase_q  <= phase_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            pbad_q   <= pbad_d;
            locked_q <= locked_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign LOCKED    = locked_q;
    assign FRAME     = frame_q;
    assign ERR       = err_q;
    assign ERR_COUNT = cnt_q;
    assign PHASE     = phase_q;

endmodule

// File: tb/tb_gp_pattern_detect.sv
// Bench for gp_pattern_detect: two instances (LOCK=2/UNLOCK=2 and LOCK=1/UNLOCK=15) on one
// stream, each checked every cycle against a position-based model, plus directed literal checks.
module tb_gp_pattern_detect;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       IN  = 1'b0;
    logic       CLR = 1'b0;
    logic [1:0] lk, fr, er;
    logic [7:0] ec0, ec1;
    logic [3:0] ph0, ph1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gp_pattern_detect #(.PATTERN_DATA(16'h00B4), .PATTERN_LEN(5'd8),
                        .LOCK_PERIODS(2), .UNLOCK_PERIODS(2)) dut0 (
        .CLK(clk), .RST(RST), .IN(IN), .CLR(CLR),
        .LOCKED(lk[0]), .FRAME(fr[0]), .ERR(er[0]), .ERR_COUNT(ec0), .PHASE(ph0));

    gp_pattern_detect #(.PATTERN_DATA(16'h00B4), .PATTERN_LEN(5'd8),
                        .LOCK_PERIODS(1), .UNLOCK_PERIODS(15)) dut1 (
        .CLK(clk), .RST(RST), .IN(IN), .CLR(CLR),
        .LOCKED(lk[1]), .FRAME(fr[1]), .ERR(er[1]), .ERR_COUNT(ec1), .PHASE(ph1));

    // Pattern B4 in transmission order.
    int pat [8] = '{1, 0, 1, 1, 0, 1, 0, 0};
    int lockp [2] = '{2, 1};
    int unlockp [2] = '{2, 15};

    // Model: st 0=hunt 1=verify 2=locked; pos = transmission index of the next expected bit.
    int m_st [2], m_pos [2], m_good [2], m_bad [2], m_pbad [2], m_cnt [2], m_fill [2];
    int m_lk [2], m_fr [2], m_er [2], m_ph [2];
    int hist [2][16];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input int r, input int b, input int c);
        int hit;
        if (r != 0) begin
            m_st[k] = 0; m_pos[k] = 0; m_good[k] = 0; m_bad[k] = 0; m_pbad[k] = 0;
            m_cnt[k] = 0; m_fill[k] = 0; m_lk[k] = 0; m_fr[k] = 0; m_er[k] = 0; m_ph[k] = 0;
            for (int i = 0; i < 16; i++) hist[k][i] = 0;
            return;
        end
        for (int i = 0; i < 15; i++) hist[k][i] = hist[k][i+1];
        hist[k][15] = b;
        hit = (m_fill[k] >= 7) ? 1 : 0;
        for (int j = 0; j < 8; j++) if (hist[k][8+j] != pat[j]) hit = 0;
        if (m_fill[k] < 8) m_fill[k]++;
        m_fr[k] = 0;
        m_er[k] = 0;
        case (m_st[k])
            0: if (hit != 0) begin
                m_pos[k] = 0; m_good[k] = 1; m_bad[k] = 0; m_pbad[k] = 0;
                m_st[k] = (lockp[k] == 1) ? 2 : 1;
            end
            1: if (b != pat[m_pos[k]]) begin
                m_st[k] = 0; m_good[k] = 0;
            end else begin
                if (m_pos[k] == 7) begin
                    m_good[k]++;
                    if (m_good[k] == lockp[k]) begin
                        m_st[k] = 2; m_bad[k] = 0; m_pbad[k] = 0;
                    end
                end
                m_pos[k] = (m_pos[k] + 1) % 8;
            end
            default: begin
                if (b != pat[m_pos[k]]) begin
                    m_er[k] = 1; m_pbad[k] = 1;
                    if (m_cnt[k] < 255) m_cnt[k]++;
                end
                if (m_pos[k] == 7) begin
                    m_fr[k] = 1;
                    m_bad[k] = (m_pbad[k] != 0) ? m_bad[k] + 1 : 0;
                    m_pbad[k] = 0;
                    if (m_bad[k] == unlockp[k]) begin
                        m_st[k] = 0; m_good[k] = 0; m_bad[k] = 0;
                    end
                end
                m_pos[k] = (m_pos[k] + 1) % 8;
            end
        endcase
        if (c != 0) m_cnt[k] = 0;
        m_lk[k] = (m_st[k] == 2) ? 1 : 0;
        m_ph[k] = (m_st[k] == 0) ? 0 : 7 - m_pos[k];
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        int r, b, c;
        forever begin
            @(posedge clk);
            r = int'(RST); b = int'(IN); c = int'(CLR);
            #1;
            for (int k = 0; k < 2; k++) model_step(k, r, b, c);
            chk("LOCKED0", int'(lk[0]), m_lk[0]);
            chk("FRAME0", int'(fr[0]), m_fr[0]);
            chk("ERR0", int'(er[0]), m_er[0]);
            chk("ERR_COUNT0", int'(ec0), m_cnt[0]);
            chk("PHASE0", int'(ph0), m_ph[0]);
            chk("LOCKED1", int'(lk[1]), m_lk[1]);
            chk("FRAME1", int'(fr[1]), m_fr[1]);
            chk("ERR1", int'(er[1]), m_er[1]);
            chk("ERR_COUNT1", int'(ec1), m_cnt[1]);
            chk("PHASE1", int'(ph1), m_ph[1]);
        end
    end

    int errs, frs, lkmax;

    task automatic one_bit(input int b, input int c);
        IN  = (b != 0);
        CLR = (c != 0);
        @(posedge clk);
        #2;
        errs += int'(er[0]);
        frs  += int'(fr[0]);
        if (lk[0]) lkmax = 1;
    endtask

    task automatic send_bits(input int from, input int n, input int bad_idx);
        int idx, b;
        errs = 0; frs = 0; lkmax = 0;
        for (int i = 0; i < n; i++) begin
            idx = (from + i) % 8;
            b = pat[idx];
            if (idx == bad_idx) b = 1 - b;
            one_bit(b, 0);
        end
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1; IN = 1'b0; CLR = 1'b0;
        repeat (n) begin @(posedge clk); #2; end
        RST = 1'b0;
    endtask

    initial begin
        int hidx, b;
        // 1: reset then clean stream
        do_reset(2);
        chk("rst_locked", int'(lk[0]), 0);
        chk("rst_count", int'(ec0), 0);
        chk("rst_phase", int'(ph0), 0);
        send_bits(0, 8, -1);
        chk("hunt_hit_phase", int'(ph0), 7);
        chk("hunt_hit_not_locked", int'(lk[0]), 0);
        chk("lock1_after8", int'(lk[1]), 1);
        send_bits(0, 7, -1);
        chk("not_locked_15", int'(lk[0]), 0);
        send_bits(7, 1, -1);
        chk("locked_16", int'(lk[0]), 1);
        chk("model_locked_16", m_lk[0], 1);
        chk("locked_16_phase", int'(ph0), 7);
        send_bits(0, 16, -1);
        chk("frames_2_periods", frs, 2);
        chk("clean_count", int'(ec0), 0);

        // 2: single bad bit at PHASE=5
        send_bits(0, 8, 2);
        chk("t2_err_pulses", errs, 1);
        chk("t2_count", int'(ec0), 1);
        chk("t2_locked", int'(lk[0]), 1);
        send_bits(0, 8, -1);
        chk("t2_clean_locked", int'(lk[0]), 1);

        // 3: two consecutive bad periods drop lock on the last bit
        send_bits(0, 8, 2);
        chk("t3_still_locked", int'(lk[0]), 1);
        send_bits(0, 8, 4);
        chk("t3_unlocked", int'(lk[0]), 0);
        chk("t3_frame_on_unlock", int'(fr[0]), 1);
        chk("t3_count", int'(ec0), 3);
        chk("model_t3_count", m_cnt[0], 3);
        send_bits(0, 15, -1);
        chk("t3_not_relocked_15", int'(lk[0]), 0);
        send_bits(7, 1, -1);
        chk("t3_relocked_16", int'(lk[0]), 1);

        // 4: unlock, then corrupt the verify period
        send_bits(0, 8, 2);
        send_bits(0, 8, 2);
        chk("t4_unlocked", int'(lk[0]), 0);
        chk("t4_count", int'(ec0), 5);
        send_bits(0, 8, -1);
        chk("t4_verify_phase", int'(ph0), 7);
        send_bits(0, 8, 4);
        chk("t4_never_locked", lkmax, 0);
        chk("t4_no_err", errs, 0);
        chk("t4_count_held", int'(ec0), 5);
        chk("t4_hunt_phase", int'(ph0), 0);
        send_bits(0, 24, -1);
        chk("t4_relocked", int'(lk[0]), 1);

        // 5: CLR beats a same-edge mismatch; then saturate the counter
        send_bits(0, 2, -1);
        one_bit(1 - pat[2], 1);
        chk("t5_err_with_clr", int'(er[0]), 1);
        chk("t5_count_cleared", int'(ec0), 0);
        chk("t5_count1_cleared", int'(ec1), 0);
        send_bits(3, 5, -1);
        hidx = 0;
        for (int i = 0; i < 300; i++) begin
            if (m_st[1] == 2) begin
                b = 1 - pat[m_pos[1]];
            end else begin
                b = pat[hidx];
                hidx = (hidx + 1) % 8;
            end
            one_bit(b, 0);
        end
        chk("t5_saturated", int'(ec1), 255);
        chk("model_t5_saturated", m_cnt[1], 255);

        // 6: reset while locked
        send_bits(0, 32, -1);
        chk("t6_locked_before", int'(lk[0]), 1);
        RST = 1'b1; IN = 1'b1;
        @(posedge clk); #2;
        RST = 1'b0;
        chk("t6_rst_locked", int'(lk[0]), 0);
        chk("t6_rst_frame", int'(fr[0]), 0);
        chk("t6_rst_err", int'(er[0]), 0);
        chk("t6_rst_count", int'(ec0), 0);
        chk("t6_rst_phase", int'(ph0), 0);
        send_bits(0, 15, -1);
        chk("t6_no_lock_15", int'(lk[0]), 0);
        send_bits(7, 1, -1);
        chk("t6_lock_16", int'(lk[0]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
